data_ram_resp: RTL and testbench

Data-memory responder for the CPU's load/store path. It sits on the RAM side of the `ram_re_en`/`ram_wr_en` interface driven by the pipeline's RAM controller. It executes one-cycle write strobes and multi-cycle reads, returning load data with a one-cycle valid pulse so the controller can schedule register write-back. It also rejects illegal requests: simultaneous read/write, out-of-range addresses, and requests made while busy.

---
 rtl/data_ram_resp_pkg.sv | 23 ++
 rtl/data_ram_resp_if.sv | 25 ++
 rtl/data_ram_resp_ram_array.sv | 27 ++
 rtl/data_ram_resp.sv | 132 +++++++++++++
 tb/tb_data_ram_resp.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_ram_resp_pkg.sv
// Shared CPU package: responder FSM encoding, load/store opcodes and a
// small address range helper used by the data-memory responder.
package data_ram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    // Load/store opcodes, shared with the pipeline's RAM controller.
    localparam logic [3:0] LDR = 4'b1101;
    localparam logic [3:0] STR = 4'b1110;

    // Wide enough for a read latency of up to 4 cycles.
    localparam int CNT_WIDTH = 3;

    // True when a word address falls inside the implemented storage.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/data_ram_resp_if.sv
// Load/store bus between the pipeline's RAM controller (master) and the
// data-memory responder (slave).
interface data_ram_resp_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  ram_re_en;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_vld;
    logic                  busy;
    logic                  err;

    modport master (
        output ram_re_en, ram_wr_en, addr, wr_data,
        input  rd_data, rd_data_vld, busy, err
    );

    modport slave (
        input  ram_re_en, ram_wr_en, addr, wr_data,
        output rd_data, rd_data_vld, busy, err
    );
endinterface

// File: rtl/data_ram_resp_ram_array.sv
// Word storage for the data-memory responder: synchronous write,
// asynchronous read. Contents are deliberately never reset.
module ram_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Commit a write at the edge where the strobe is sampled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: accepts single-cycle write strobes and multi-cycle
// reads from the RAM controller, pulses rd_data_vld when load data is ready
// and pulses err for any request it has to reject.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input logic           clk,
    input logic           rst,
    data_ram_resp_if.slave bus
);

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [ADDR_WIDTH-1:0] lat_addr_next;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_next;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  vld_q;
    logic                  vld_next;
    logic                  err_q;
    logic                  err_next;
    logic                  mem_we;
    logic                  strobe;
    logic                  req_in_range;
    logic                  lat_in_range;

    assign strobe       = bus.ram_re_en | bus.ram_wr_en;
    assign req_in_range = addr_in_range(32'(bus.addr), DEPTH);
    assign lat_in_range = addr_in_range(32'(lat_addr), DEPTH);

    ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.addr),
        .wdata (bus.wr_data),
        .raddr (lat_addr),
        .rdata (mem_rdata)
    );

    // Control and output registers; memory contents survive reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            rd_data_q <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            lat_addr  <= lat_addr_next;
            rd_data_q <= rd_data_next;
            vld_q     <= vld_next;
            err_q     <= err_next;
        end
    end

    // Next-state decode: accept or reject strobes, count down the read
    // latency and capture load data when the read completes.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        lat_addr_next = lat_addr;
        rd_data_next  = rd_data_q;
        vld_next      = 1'b0;
        err_next      = 1'b0;
        mem_we        = 1'b0;

        case (state)
            IDLE: begin
                if (bus.ram_re_en && bus.ram_wr_en) begin
                    err_next = 1'b1;
                end else if (bus.ram_wr_en) begin
                    if (req_in_range) begin
                        mem_we = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (bus.ram_re_en) begin
                    lat_addr_next = bus.addr;
                    cnt_next      = CNT_WIDTH'(READ_LATENCY - 1);
                    state_next    = (READ_LATENCY == 1) ? RD_DONE : RD_WAIT;
                end
            end

            RD_WAIT: begin
                err_next = strobe;
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end
                if (cnt <= CNT_WIDTH'(1)) begin
                    state_next = RD_DONE;
                end
            end

            RD_DONE: begin
                vld_next   = 1'b1;
                state_next = IDLE;
                if (lat_in_range) begin
                    rd_data_next = mem_rdata;
                    err_next     = strobe;
                end else begin
                    rd_data_next = '0;
                    err_next     = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_data_vld = vld_q;
    assign bus.err         = err_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_data_ram_resp.sv
// Randomised scoreboard bench for data_ram_resp. The reference model keeps
// a word array and the time window of the one outstanding read; responses
// are queued by the edge at which they must appear and a monitor compares
// every cycle.
module tb_data_ram_resp;
    import data_ram_resp_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 200;
    localparam int RL    = 2;

    typedef struct {
        int            edge_no;
        logic          vld;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_ram_resp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    data_ram_resp #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          sb [$];
    int            checks    = 0;
    int            errors    = 0;
    int            edge_n    = 0;
    int            busy_from = -100;
    int            rd_until  = -100;
    logic [DW-1:0] held      = '0;
    logic [DW-1:0] model_mem [DEPTH];

    // Free-running clock.
    always #5 clk = ~clk;

    // Count rising edges so responses can be tied to the edge that makes them.
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %h, required %h", name, edge_n, act, exp);
        end
    endtask

    // Keep the scoreboard ordered by edge; responses sharing an edge merge.
    function automatic void push_event(input int e, input logic vld, input logic err, input logic [DW-1:0] d);
        exp_t item;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].edge_no == e) begin
                sb[i].vld = sb[i].vld | vld;
                sb[i].err = sb[i].err | err;
                if (vld) sb[i].data = d;
                return;
            end
            if (sb[i].edge_no > e) begin
                item = '{edge_no: e, vld: vld, err: err, data: d};
                sb.insert(i, item);
                return;
            end
        end
        item = '{edge_no: e, vld: vld, err: err, data: d};
        sb.push_back(item);
    endfunction

    // Drive one cycle of strobes (op bit0 = write, bit1 = read) and record
    // what the responder must do once it samples them at the next edge.
    task automatic apply_stimulus(input int op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   t;
        logic in_rng;
        @(posedge clk);
        #1;
        t               = edge_n + 1;
        bus.ram_wr_en   = op[0];
        bus.ram_re_en   = op[1];
        bus.addr        = a;
        bus.wr_data     = d;
        in_rng          = (int'(a) < DEPTH);
        if (op != 0) begin
            if (t <= rd_until) begin
                push_event(t, 1'b0, 1'b1, '0);
            end else if (op == 3) begin
                push_event(t, 1'b0, 1'b1, '0);
            end else if (op == 1) begin
                if (in_rng) model_mem[a] = d;
                else        push_event(t, 1'b0, 1'b1, '0);
            end else begin
                busy_from = t;
                rd_until  = t + RL;
                push_event(t + RL, 1'b1, !in_rng, in_rng ? model_mem[a] : '0);
            end
        end
    endtask

    // Monitor: compare busy, any response and the held load data every cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            check_output("busy", DW'(bus.busy), DW'((edge_n >= busy_from) && (edge_n < rd_until)));
            if (sb.size() > 0 && sb[0].edge_no == edge_n) begin
                e = sb.pop_front();
                check_output("rd_data_vld", DW'(bus.rd_data_vld), DW'(e.vld));
                check_output("err", DW'(bus.err), DW'(e.err));
                if (e.vld) held = e.data;
            end else if (bus.rd_data_vld || bus.err) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_response at edge %0d: vld=%b err=%b, required vld=0 err=0",
                         edge_n, bus.rd_data_vld, bus.err);
            end
            check_output("rd_data", bus.rd_data, held);
        end
    end

    initial begin
        bus.ram_re_en = 1'b0;
        bus.ram_wr_en = 1'b0;
        bus.addr      = '0;
        bus.wr_data   = '0;
        $display("[TB] opcodes LDR=%b STR=%b", LDR, STR);

        #12;
        check_output("reset_rd_data", bus.rd_data, '0);
        check_output("reset_vld", DW'(bus.rd_data_vld), '0);
        check_output("reset_busy", DW'(bus.busy), '0);
        check_output("reset_err", DW'(bus.err), '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Give every implemented word a known value.
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1, AW'(i), $urandom);

        // Write then read back through the full latency.
        apply_stimulus(1, 8'h10, 32'hDEADBEEF);
        apply_stimulus(2, 8'h10, '0);
        repeat (RL + 1) apply_stimulus(0, '0, '0);

        // Read on the cycle right after a write sees the new word.
        apply_stimulus(1, 8'h05, 32'h0000_0001);
        apply_stimulus(2, 8'h05, '0);
        repeat (RL + 1) apply_stimulus(0, '0, '0);

        // A write while busy is dropped; readback shows the old word.
        apply_stimulus(2, 8'h20, '0);
        apply_stimulus(1, 8'h20, 32'h1234_5678);
        repeat (RL) apply_stimulus(0, '0, '0);
        apply_stimulus(2, 8'h20, '0);
        repeat (RL + 1) apply_stimulus(0, '0, '0);

        // Both strobes together do nothing but flag an error.
        apply_stimulus(3, 8'h40, 32'h5555_5555);
        apply_stimulus(0, '0, '0);
        apply_stimulus(2, 8'h40, '0);
        repeat (RL + 1) apply_stimulus(0, '0, '0);

        // Beyond the implemented depth: write faults, read returns zero with err.
        apply_stimulus(1, 8'hF0, 32'hCAFE_F00D);
        apply_stimulus(2, 8'hF0, '0);
        repeat (RL + 1) apply_stimulus(0, '0, '0);

        // Back-to-back read in the completion cycle is accepted.
        apply_stimulus(2, 8'h07, '0);
        repeat (RL) apply_stimulus(0, '0, '0);
        apply_stimulus(2, 8'h08, '0);
        repeat (RL + 1) apply_stimulus(0, '0, '0);

        // Reset while a read is waiting abandons it.
        apply_stimulus(2, 8'h30, '0);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.ram_re_en = 1'b0;
        bus.ram_wr_en = 1'b0;
        #1;
        check_output("midread_rd_data", bus.rd_data, '0);
        check_output("midread_vld", DW'(bus.rd_data_vld), '0);
        check_output("midread_busy", DW'(bus.busy), '0);
        check_output("midread_err", DW'(bus.err), '0);
        sb.delete();
        busy_from = -100;
        rd_until  = -100;
        held      = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (RL + 2) apply_stimulus(0, '0, '0);
        apply_stimulus(2, 8'h10, '0);
        repeat (RL + 1) apply_stimulus(0, '0, '0);

        // Random traffic, including strobes while busy and out-of-range words.
        for (int n = 0; n < 400; n++) begin
            int r;
            int op;
            r  = $urandom_range(0, 9);
            op = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            apply_stimulus(op, AW'($urandom_range(0, 255)), $urandom);
        end
        apply_stimulus(0, '0, '0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d responses outstanding, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
